// File: rtl/glitchless_arb.sv
// rtl/glitchless_arb.sv - round-robin arbiter sharing one glitchless read controller; optional ARB_TIMEOUT_EN abort
module glitchless_arb #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             ctl_go,
  input  logic             ctl_ds,
  input  logic             ctl_rd,
  output logic             err
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GO      = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_RELEASE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [PW-1:0]    rr_ptr, rr_next;
  logic [PW-1:0]    owner, owner_next;
  logic [N_REQ-1:0] grant_next, done_next;
  logic             busy_next, go_next;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    owner_succ;
  int               scan_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt, tmo_next, tmo_inc;
  logic          err_next;

  // saturating increment so a long stall can never wrap the counter
  assign tmo_inc = (tmo_cnt == CW'(TIMEOUT_CYCLES)) ? tmo_cnt : tmo_cnt + 1'b1;
`else
  assign err = 1'b0;
`endif

  // next owner index after the current one, wrapping at N_REQ (safe for non-power-of-2)
  assign owner_succ = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // round-robin pick: scan offsets high to low so the smallest offset from rr_ptr wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(scan_idx);
      end
    end
  end

  // next-state and next-output decode; pulses default low, held outputs default to current
  always_comb begin
    state_next = state;
    grant_next = grant;
    done_next  = '0;
    busy_next  = busy;
    go_next    = 1'b0;
    rr_next    = rr_ptr;
    owner_next = owner;
`ifdef ARB_TIMEOUT_EN
    tmo_next   = tmo_cnt;
    err_next   = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          go_next              = 1'b1;
          busy_next            = 1'b1;
          owner_next           = pick_idx;
          state_next           = ARB_GO;
`ifdef ARB_TIMEOUT_EN
          tmo_next             = '0;
`endif
        end
      end
      ARB_GO: begin
        // ds from the controller cannot be ours yet; ignore it here
        state_next = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (ctl_ds) begin
          done_next  = grant;
          grant_next = '0;
          busy_next  = 1'b0;
          rr_next    = owner_succ;
          state_next = ARB_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_inc == CW'(TIMEOUT_CYCLES)) begin
          err_next   = 1'b1;
          grant_next = '0;
          busy_next  = 1'b0;
          rr_next    = owner_succ;
          state_next = ARB_RELEASE;
        end else begin
          tmo_next = tmo_inc;
        end
`endif
      end
      ARB_RELEASE: begin
        // one guaranteed idle cycle so go never lands on the controller's DONE state
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      ctl_go <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      err     <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      done   <= done_next;
      busy   <= busy_next;
      ctl_go <= go_next;
      rr_ptr <= rr_next;
      owner  <= owner_next;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt <= tmo_next;
      err     <= err_next;
`endif
    end
  end

  param_ok: assert property (@(posedge clk) (N_REQ >= 2) && (TIMEOUT_CYCLES >= 1));

`ifndef ARB_TIMEOUT_EN
  // controller must be quiet whenever we are idle; after an abort it may still be mid-read
  idle_quiet: assert property (@(posedge clk) disable iff (reset)
    (state == ARB_IDLE) |-> !(ctl_rd || ctl_ds));
`endif

endmodule

// File: doc/glitchless_arb.md
Name: glitchless_arb

Overview:
- Round-robin arbiter that shares one glitchless memory-read controller (go/ws in, rd/ds out) between N_REQ requesters.
- Picks one requester, pulses the controller's go for one cycle, and holds the grant until the controller reports done (ds).
- Returns a per-requester done pulse, then re-arbitrates.
- Sits between the requesting engines and the controller. The memory's ws goes straight to the controller, not through this block.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT_CYCLES, 16, maximum ARB_BUSY cycles before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request per requester; level, held until that requester's done.
- grant  out  N_REQ  one-hot owner of the controller; all-zero when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high while any grant is held.
- ctl_go  out  1  connects to the controller's go.
- ctl_ds  in  1  from the controller's ds.
- ctl_rd  in  1  from the controller's rd; used for the protocol check only.
- err  out  1  one-cycle abort pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset values: grant=0, done=0, busy=0, ctl_go=0, err=0, state=ARB_IDLE, rr_ptr=0, timeout counter=0.
- Reset applied mid-transaction clears everything immediately. The controller is reset by the same signal.
- States: ARB_IDLE, ARB_GO, ARB_BUSY, ARB_RELEASE.
- ARB_IDLE:
  - If req != 0, select the first set bit searching from rd_ptr upward with wrap-around (index rr_ptr, rr_ptr+1, ... mod N_REQ).
  - Next edge: grant <= onehot(winner), ctl_go <= 1, busy <= 1, go to ARB_GO.
- ARB_GO:
  - Lasts exactly one cycle. Next edge: ctl_go <= 0, go to ARB_BUSY.
  - ctl_ds is ignored in this state.
- ARB_BUSY:
  - Wait for ctl_ds=1.
  - On the edge that samples ctl_ds=1: done <= grant, grant <= 0, busy <= 0, rr_ptr <= (winner+1) mod N_REQ, go to ARB_RELEASE.
- ARB_RELEASE:
  - Lasts one cycle. Next edge: done <= 0, go to ARB_IDLE.
  - Guarantees at least one idle cycle between transactions, so go is never asserted while the controller is in its DONE state.
- Latency with ws=0:
  - req sampled at edge E → grant/ctl_go high after E+1.
  - Controller READ at E+2, DLY at E+3, DONE (ds=1) at E+4.
  - done high after E+5 → next grant possible after E+7.
  - Each extra DLY→READ loop caused by ws=1 adds 2 cycles.
- req changes:
  - The owner dropping req mid-transaction is ignored; the transaction still completes and done still pulses.
  - A non-owner raising req waits. req bits for other indices are never sampled outside ARB_IDLE.
- Simultaneous requests: the rr_ptr order decides. After owner i completes, i has the lowest priority in the next arbitration.
- Protocol check (assertion, not logic): ctl_rd or ctl_ds high in ARB_IDLE is an error.
- Widths:
  - rr_ptr is $clog2(N_REQ) bits and wraps modulo N_REQ; it must not overflow for non-power-of-2 N_REQ.
  - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each ARB_BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with ctl_ds still 0: err <= 1 for one cycle, grant <= 0, busy <= 0, done stays 0, rr_ptr <= winner+1, go to ARB_RELEASE.
  - The counter clears on entry to ARB_GO.
- Not defined: no counter logic; ARB_BUSY waits indefinitely; err is constant 0.

Test Plan:
- Reset mid-transaction: assert reset in ARB_BUSY → all outputs 0 asynchronously; first req after release is granted to the lowest set index ≥ 0.
- Single request, N_REQ=4, ws=0: req=0001 at edge 0 → grant=0001 and ctl_go=1 for exactly one cycle after edge 1; done=0001 for one cycle after edge 5; busy high across edges 1–5.
- Wait states: same as above with ws=1 for 2 DLY samples → done delayed by 4 cycles, grant held steady throughout, no second go.
- Round-robin: req=1111 held, serviced to completion → grant order 0001, 0010, 0100, 1000, 0001; exactly one go per grant; at least one idle cycle between done and the next go.
- Owner drops req: req=0100 dropped one cycle after grant → transaction completes; done=0100 still pulses; then idle.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ws stuck 1 → err pulses 16 cycles after entering ARB_BUSY, grant clears, done stays 0, next requester is served. Without the macro, the grant is held indefinitely and err stays 0.
